mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit: alignment check, single-access bus master, load extraction
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] badvaddr_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_op;
  logic [1:0]  r_off;
  logic        r_kill;
  logic [31:0] r_lbuf;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_wdata;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_misaligned;
  logic        w_issue;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic        w_done_is_load;

  always_comb begin
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    w_sel        = 4'b0000;
    w_wdata      = reg2_i;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin
        w_is_load = 1'b1;
        w_sel     = 4'b0001 << mem_addr_i[1:0];
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        w_is_load    = 1'b1;
        w_sel        = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_misaligned = mem_addr_i[0];
      end
      EXE_LW_OP: begin
        w_is_load    = 1'b1;
        w_sel        = 4'b1111;
        w_misaligned = |mem_addr_i[1:0];
      end
      EXE_SB_OP: begin
        w_is_store = 1'b1;
        w_sel      = 4'b0001 << mem_addr_i[1:0];
        w_wdata    = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        w_is_store   = 1'b1;
        w_sel        = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{reg2_i[15:0]}};
        w_misaligned = mem_addr_i[0];
      end
      EXE_SW_OP: begin
        w_is_store   = 1'b1;
        w_sel        = 4'b1111;
        w_misaligned = |mem_addr_i[1:0];
      end
      default: ;
    endcase
  end

  // A flushed instruction in IDLE never reaches the bus.
  assign w_issue = (r_state == S_IDLE) && (w_is_load || w_is_store) &&
                   !w_misaligned && !flush_i && !rst;

  always_comb begin
    w_byte         = r_lbuf[{r_off, 3'b000} +: 8];
    w_half         = r_off[1] ? r_lbuf[31:16] : r_lbuf[15:0];
    w_done_is_load = 1'b1;
    case (r_op)
      EXE_LB_OP:  w_load_val = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: w_load_val = {24'd0, w_byte};
      EXE_LH_OP:  w_load_val = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: w_load_val = {16'd0, w_half};
      EXE_LW_OP:  w_load_val = r_lbuf;
      default: begin
        w_load_val     = r_lbuf;
        w_done_is_load = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_BUSY;
      S_BUSY:  if (bus_ack_i) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 8'd0;
      r_off       <= 2'd0;
      r_kill      <= 1'b0;
      r_lbuf      <= 32'd0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_sel   <= 4'd0;
      r_bus_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {mem_addr_i[31:2], 2'b00};
            r_bus_sel   <= w_sel;
            r_bus_wdata <= w_wdata;
            r_op        <= aluop_i;
            r_off       <= mem_addr_i[1:0];
          end
        end
        S_BUSY: begin
          // The bus cannot be retracted; a flush only marks the result as dead.
          if (flush_i) r_kill <= 1'b1;
          if (bus_ack_i) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_lbuf    <= bus_rdata_i;
          end
        end
        S_DONE:  r_kill <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_sel_o   = r_bus_sel;
  assign bus_wdata_o = r_bus_wdata;

  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    stallreq_o = 1'b0;
    adel_o     = 1'b0;
    ades_o     = 1'b0;
    badvaddr_o = 32'd0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          wd_o    = wd_i;
          wdata_o = wdata_i;
          if (w_is_load || w_is_store) begin
            if (w_misaligned) begin
              adel_o     = w_is_load;
              ades_o     = w_is_store;
              badvaddr_o = mem_addr_i;
            end else begin
              stallreq_o = w_issue;
            end
          end else begin
            wreg_o = wreg_i && !flush_i;
          end
        end
        S_BUSY: begin
          wd_o       = wd_i;
          stallreq_o = 1'b1;
        end
        S_DONE: begin
          wd_o    = wd_i;
          wdata_o = w_load_val;
          wreg_o  = wreg_i && w_done_is_load && !r_kill && !flush_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - randomized self-checking bench for mem_lsu against a byte-level memory model
module tb_mem_lsu;

  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB, NOP = 8'h25;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, flush_i, bus_ack_i;
  logic        bus_req_o, bus_we_o, wreg_o, stallreq_o, adel_o, ades_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wdata_o, badvaddr_o;
  logic [3:0]  bus_sel_o;
  logic [4:0]  wd_o;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // bmem is what the bus slave holds; mmem is the architectural byte view.
  logic [31:0] bmem [16];
  logic [7:0]  mmem [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [7:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction

  function automatic bit op_store(input logic [7:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input int a6);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < op_size(op); i++) v = v | (32'(mmem[a6 + i]) << (8 * i));
    if (op == LB && v[7]) v = v | 32'hFFFF_FF00;
    if (op == LH && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    bmem[idx] = v;
    for (int k = 0; k < 4; k++) mmem[4 * idx + k] = v[8 * k +: 8];
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wd, input logic wr, input int ack_wait, input int flush_at,
                        output int o_stall, output logic [3:0] o_sel, output logic [31:0] o_addr,
                        output logic o_we, output logic [31:0] o_bwdata, output logic o_wreg,
                        output logic [31:0] o_wdata, output logic o_adel, output logic [31:0] o_badv);
    int sz, a6;
    bit mem, mis, killed;
    logic [3:0] e_sel;
    logic [31:0] e_bw, alu;
    sz = op_size(op);
    a6 = int'(addr[5:0]);
    mem = op_load(op) || op_store(op);
    mis = mem && ((addr % sz) != 0);
    alu = $urandom;
    e_sel = 4'd0;
    for (int i = 0; i < sz; i++) e_sel[int'(addr[1:0]) + i] = 1'b1;
    for (int k = 0; k < 4; k++) e_bw[8 * k +: 8] = data[8 * (k % sz) +: 8];
    aluop_i = op; mem_addr_i = addr; reg2_i = data; wd_i = wd; wreg_i = wr; wdata_i = alu;
    flush_i = 1'b0; bus_ack_i = 1'b0;
    o_stall = 0; o_sel = 4'd0; o_addr = 32'd0; o_we = 1'b0; o_bwdata = 32'd0;
    o_wreg = 1'b0; o_wdata = 32'd0;
    @(negedge clk);
    o_adel = adel_o; o_badv = badvaddr_o;
    if (stallreq_o) o_stall++;
    if (!mem) begin
      chk("nm_wd", 32'(wd_o), 32'(wd));
      chk("nm_wreg", 32'(wreg_o), 32'(wr));
      chk("nm_wdata", wdata_o, alu);
      chk("nm_stall", 32'(stallreq_o), 32'd0);
    end else if (mis) begin
      chk("mis_adel", 32'(adel_o), 32'(op_load(op)));
      chk("mis_ades", 32'(ades_o), 32'(op_store(op)));
      chk("mis_badv", badvaddr_o, addr);
      chk("mis_wreg", 32'(wreg_o), 32'd0);
      chk("mis_stall", 32'(stallreq_o), 32'd0);
    end else begin
      chk("iss_stall", 32'(stallreq_o), 32'd1);
      chk("iss_exc", {30'd0, adel_o, ades_o}, 32'd0);
      chk("iss_badv", badvaddr_o, 32'd0);
    end
    @(posedge clk); #1;
    if (!mem || mis) begin
      aluop_i = NOP;
      @(negedge clk);
      chk("no_req", 32'(bus_req_o), 32'd0);
      chk("no_stall", 32'(stallreq_o), 32'd0);
      @(posedge clk); #1;
      return;
    end
    killed = 1'b0;
    for (int c = 0; c <= ack_wait; c++) begin
      flush_i = (c == flush_at);
      bus_ack_i = (c == ack_wait);
      bus_rdata_i = (c == ack_wait) ? bmem[addr[5:2]] : $urandom;
      if (flush_i) killed = 1'b1;
      @(negedge clk);
      if (stallreq_o) o_stall++;
      chk("busy_req", 32'(bus_req_o), 32'd1);
      chk("busy_addr", bus_addr_o, {addr[31:2], 2'b00});
      chk("busy_sel", 32'(bus_sel_o), 32'(e_sel));
      chk("busy_we", 32'(bus_we_o), 32'(op_store(op)));
      if (op_store(op)) chk("busy_wdata", bus_wdata_o, e_bw);
      o_sel = bus_sel_o; o_addr = bus_addr_o; o_we = bus_we_o; o_bwdata = bus_wdata_o;
      if (bus_ack_i && bus_we_o)
        for (int k = 0; k < 4; k++)
          if (bus_sel_o[k]) bmem[addr[5:2]][8 * k +: 8] = bus_wdata_o[8 * k +: 8];
      @(posedge clk); #1;
    end
    flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = $urandom;
    @(negedge clk);
    if (stallreq_o) o_stall++;
    o_wreg = wreg_o; o_wdata = wdata_o;
    chk("done_stall", 32'(stallreq_o), 32'd0);
    chk("done_req", 32'(bus_req_o), 32'd0);
    chk("done_wd", 32'(wd_o), 32'(wd));
    chk("done_wreg", 32'(wreg_o), 32'(op_load(op) && wr && !killed));
    if (op_load(op) && !killed) chk("done_wdata", wdata_o, model_load(op, a6));
    chk("stall_cycles", 32'(o_stall), 32'(ack_wait + 2));
    if (op_store(op)) for (int i = 0; i < sz; i++) mmem[a6 + i] = data[8 * i +: 8];
    @(posedge clk); #1;
    aluop_i = NOP;
  endtask

  int st;
  logic [3:0] sel;
  logic [31:0] badr, bwd, wdo, badv, a;
  logic we, wro, adl;
  logic [7:0] ops [9] = '{LB, LBU, LH, LHU, LW, SB, SH, SW, NOP};
  logic [7:0] op;
  int fa, aw;

  initial begin
    rst = 1'b1; aluop_i = NOP; mem_addr_i = 0; reg2_i = 0; wd_i = 0; wreg_i = 0;
    wdata_i = 32'h1234_5678; flush_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
    for (int w = 0; w < 16; w++) preload(w, $urandom);
    @(posedge clk); #1;
    aluop_i = LW; mem_addr_i = 32'h100; wreg_i = 1'b1; wd_i = 5'd3;
    @(negedge clk);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_bwdata", bus_wdata_o, 32'd0);
    chk("rst_outs", {wdata_o[30:0], wreg_o}, 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    chk("rst_exc", badvaddr_o | {30'd0, adel_o, ades_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = NOP;

    preload(0, 32'h80FF_1234);
    run_op(LB, 32'h1003, 32'h0, 5'd7, 1'b1, 0, -1, st, sel, badr, we, bwd, wro, wdo, adl, badv);
    chk("lb_sel", 32'(sel), 32'h8);
    chk("lb_addr", badr, 32'h1000);
    chk("lb_wdata", wdo, 32'hFFFF_FF80);
    chk("lb_wreg", 32'(wro), 32'd1);

    run_op(SH, 32'h2002, 32'h0000_ABCD, 5'd0, 1'b0, 2, -1, st, sel, badr, we, bwd, wro, wdo, adl, badv);
    chk("sh_we", 32'(we), 32'd1);
    chk("sh_sel", 32'(sel), 32'hC);
    chk("sh_bwdata", bwd, 32'hABCD_ABCD);
    chk("sh_stall4", 32'(st), 32'd4);
    chk("sh_wreg", 32'(wro), 32'd0);

    run_op(LW, 32'h3001, 32'h0, 5'd2, 1'b1, 0, -1, st, sel, badr, we, bwd, wro, wdo, adl, badv);
    chk("lw_adel", 32'(adl), 32'd1);
    chk("lw_badv", badv, 32'h3001);

    preload(0, 32'hBEEF_0000);
    run_op(LHU, 32'h4002, 32'h0, 5'd9, 1'b1, 2, 1, st, sel, badr, we, bwd, wro, wdo, adl, badv);
    chk("lhu_flush_wreg", 32'(wro), 32'd0);
    chk("lhu_sel", 32'(sel), 32'hC);

    run_op(LW, 32'h1010, 32'h0, 5'd4, 1'b1, 1, 1, st, sel, badr, we, bwd, wro, wdo, adl, badv);
    chk("flush_ack_wreg", 32'(wro), 32'd0);

    aluop_i = NOP; wreg_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    chk("idle_flush_wreg", 32'(wreg_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;

    aluop_i = LW; mem_addr_i = 32'h1008; wreg_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy_stall", 32'(stallreq_o), 32'd0);
    chk("rstbusy_wreg", 32'(wreg_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus_ack_i = 1'b1; aluop_i = NOP; wdata_i = 32'hCAFE_0001;
    @(negedge clk);
    chk("rstbusy_req", 32'(bus_req_o), 32'd0);
    chk("rstbusy_idle", wdata_o, 32'hCAFE_0001);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("ack_ignored_req", 32'(bus_req_o), 32'd0);
    chk("ack_ignored_stall", 32'(stallreq_o), 32'd0);
    chk("ack_ignored_idle", wdata_o, 32'hCAFE_0001);
    @(posedge clk); #1;

    for (int w = 0; w < 16; w++) preload(w, $urandom);
    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 8)];
      a = 32'h0000_1000 | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a - (a % op_size(op));
      aw = $urandom_range(0, 3);
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, aw) : -1;
      run_op(op, a, $urandom, 5'($urandom), 1'($urandom), aw, fa,
             st, sel, badr, we, bwd, wro, wdo, adl, badv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
